axi_tagctrl_r_merge: RTL and testbench

Multi-outstanding R-channel tag merger for the CHERI tag controller. It sits between the memory-side AXI R channel and the slave-port R channel. It queues read descriptors and memory R beats, and attaches the capability tag bits for every capability covered by each beat to the R `user` field. Tag words arrive in order from the tag cache. Compared with the single-descriptor, single-tag-bit unit, it adds:
- a descriptor FIFO,
- multi-capability beats,
- parametrised tag-word width,
- tag-error propagation,
- locally generated `last` with length checking.

---
 rtl/axi_tagctrl_r_merge.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_tagctrl_r_merge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tagctrl_r_merge.sv
// axi_tagctrl_r_merge
//   Multi-outstanding R-channel tag merger. Read descriptors and memory R
//   beats are queued independently. Tag words from the tag cache are held
//   in a single register. Each beat leaves with the tag bits of every
//   capability it covers placed in the R user field.
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   tagctrl_desc_i/_valid_i/_ready_o    read descriptor in
//   r_chan_mst_i/r_chan_valid_i/_ready_o memory-side R beat in
//   tagc_inp_r_i/_valid_i/_ready_o      tag word (data + err) in
//   r_chan_slv_o/_valid_o/_ready_i      merged R beat out
//   len_err_o                           memory last disagreed with length

package tagctrl_r_merge_pkg;
    typedef struct packed {
        int unsigned AxiDataWidth;
        int unsigned CapSize;
        int unsigned TagRFifoDepth;
    } cfg_t;

    localparam cfg_t DefaultCfg = '{AxiDataWidth: 128, CapSize: 128, TagRFifoDepth: 2};

    typedef struct packed {
        logic [47:0] a_x_addr;
        logic [2:0]  a_x_size;
        logic [7:0]  a_x_len;
        logic [3:0]  a_x_id;
        logic [1:0]  a_x_burst;
    } desc_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } tagc_inp_t;

    typedef struct packed {
        logic [3:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
        logic [3:0]   user;
    } r_chan_t;
endpackage

// Plain ring-buffer FIFO; the head shows a pushed entry one cycle later.
module axi_tagctrl_r_merge_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= inc(wptr_q);
            if (do_pop)  rptr_q <= inc(rptr_q);
            cnt_q <= cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

module axi_tagctrl_r_merge #(
    parameter tagctrl_r_merge_pkg::cfg_t Cfg = tagctrl_r_merge_pkg::DefaultCfg,
    parameter int unsigned DescFifoDepth = 4,
    parameter int unsigned TagWordWidth  = 64,
    parameter type tagctrl_desc_t = tagctrl_r_merge_pkg::desc_t,
    parameter type tagc_inp_t     = tagctrl_r_merge_pkg::tagc_inp_t,
    parameter type r_chan_t       = tagctrl_r_merge_pkg::r_chan_t
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  tagctrl_desc_t tagctrl_desc_i,
    input  logic          tagctrl_desc_valid_i,
    output logic          tagctrl_desc_ready_o,
    input  r_chan_t       r_chan_mst_i,
    input  logic          r_chan_valid_i,
    output logic          r_chan_ready_o,
    input  tagc_inp_t     tagc_inp_r_i,
    input  logic          tagc_inp_r_valid_i,
    output logic          tagc_inp_r_ready_o,
    output r_chan_t       r_chan_slv_o,
    output logic          r_chan_slv_valid_o,
    input  logic          r_chan_slv_ready_i,
    output logic          len_err_o
);
    localparam int unsigned CapsPerBeat = (Cfg.AxiDataWidth / Cfg.CapSize > 1) ?
                                          Cfg.AxiDataWidth / Cfg.CapSize : 1;
    localparam int unsigned CapShift = $clog2(Cfg.CapSize / 8);
    // Log2 of the byte span covered by one tag word.
    localparam int unsigned RegShift = $clog2(TagWordWidth * Cfg.CapSize / 8);
    localparam int unsigned TiW      = (TagWordWidth > 1) ? $clog2(TagWordWidth) : 1;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e        state_q, state_d;
    tagctrl_desc_t desc_head, ctx_q;
    r_chan_t       beat_head, slv_d;
    logic          desc_full, desc_empty, desc_pop, load;
    logic          beat_full, beat_empty;

    localparam int unsigned AddrW = $bits(ctx_q.a_x_addr);
    localparam int unsigned LenW  = $bits(ctx_q.a_x_len);

    logic [LenW-1:0]         cnt_q;
    logic [AddrW-1:0]        num_bytes, incr_addr, next_addr;
    logic [TiW-1:0]          ti;
    logic [TagWordWidth-1:0] tag_q, tag_shift;
    logic                    tv_q, err_q;
    logic                    slv_hs, is_last, region_chg, tag_release, tag_hs;

    assign tagctrl_desc_ready_o = !desc_full;
    assign r_chan_ready_o       = !beat_full;

    axi_tagctrl_r_merge_fifo #(.Depth(DescFifoDepth), .T(tagctrl_desc_t)) i_desc_fifo (
        .clk_i, .rst_ni,
        .push_i (tagctrl_desc_valid_i),
        .data_i (tagctrl_desc_i),
        .pop_i  (desc_pop),
        .data_o (desc_head),
        .full_o (desc_full),
        .empty_o(desc_empty)
    );

    axi_tagctrl_r_merge_fifo #(.Depth(Cfg.TagRFifoDepth), .T(r_chan_t)) i_beat_fifo (
        .clk_i, .rst_ni,
        .push_i (r_chan_valid_i),
        .data_i (r_chan_mst_i),
        .pop_i  (slv_hs),
        .data_o (beat_head),
        .full_o (beat_full),
        .empty_o(beat_empty)
    );

    assign r_chan_slv_valid_o = (state_q == ACTIVE) && tv_q && !beat_empty;
    assign slv_hs             = r_chan_slv_valid_o && r_chan_slv_ready_i;
    assign is_last            = (cnt_q == ctx_q.a_x_len);
    assign len_err_o          = slv_hs && (beat_head.last != is_last);

    // INCR steps to the next size-aligned address; FIXED (burst 0) holds.
    assign num_bytes  = AddrW'(1) << ctx_q.a_x_size;
    assign incr_addr  = (ctx_q.a_x_addr + num_bytes) & ~(num_bytes - AddrW'(1));
    assign next_addr  = (ctx_q.a_x_burst == 2'b00) ? ctx_q.a_x_addr : incr_addr;
    assign region_chg = (next_addr >> RegShift) != (ctx_q.a_x_addr >> RegShift);

    // Releasing the word in the same cycle lets the next word load at once,
    // so region and burst boundaries cost no bubble.
    assign tag_release        = slv_hs && (is_last || region_chg);
    assign tagc_inp_r_ready_o = !tv_q || tag_release;
    assign tag_hs             = tagc_inp_r_valid_i && tagc_inp_r_ready_o;

    assign ti        = TiW'(ctx_q.a_x_addr >> CapShift);
    assign tag_shift = tag_q >> ti;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        desc_pop = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!desc_empty) begin
                    desc_pop = 1'b1;
                    load     = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (slv_hs && is_last) begin
                    if (!desc_empty) begin
                        desc_pop = 1'b1;
                        load     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctx_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            ctx_q <= desc_head;
            cnt_q <= '0;
        end else if (slv_hs) begin
            ctx_q.a_x_addr <= next_addr;
            cnt_q          <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tv_q  <= 1'b0;
            err_q <= 1'b0;
            tag_q <= '0;
        end else if (tag_hs) begin
            tv_q  <= 1'b1;
            err_q <= tagc_inp_r_i.err;
            tag_q <= tagc_inp_r_i.data;
        end else if (tag_release) begin
            tv_q <= 1'b0;
        end
    end

    always_comb begin
        slv_d      = beat_head;
        slv_d.id   = ctx_q.a_x_id;
        slv_d.last = is_last;
        slv_d.user = '0;
        for (int unsigned i = 0; i < CapsPerBeat; i++) slv_d.user[i] = tag_shift[i];
        // A tag error hides the tags and upgrades OKAY/EXOKAY to SLVERR.
        if (err_q) begin
            slv_d.user = '0;
            if (!beat_head.resp[1]) slv_d.resp = 2'b10;
        end
    end

    assign r_chan_slv_o = slv_d;
endmodule

// File: tb/tb_axi_tagctrl_r_merge.sv
module tb_axi_tagctrl_r_merge;
    import tagctrl_r_merge_pkg::*;

    typedef struct packed {
        logic [3:0]   id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic         last;
        logic [3:0]   user;
    } r512_t;

    localparam cfg_t CfgA = '{AxiDataWidth: 128, CapSize: 128, TagRFifoDepth: 8};
    localparam cfg_t CfgB = '{AxiDataWidth: 512, CapSize: 128, TagRFifoDepth: 4};

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    // DUT A: 128-bit data, one capability per beat
    desc_t     desc;   logic desc_valid = 0, desc_ready;
    r_chan_t   rin;    logic r_valid = 0, r_ready;
    tagc_inp_t tag;    logic tag_valid = 0, tag_ready;
    r_chan_t   rout;   logic out_valid, out_ready = 0, len_err;

    axi_tagctrl_r_merge #(.Cfg(CfgA), .DescFifoDepth(4), .TagWordWidth(64),
        .tagctrl_desc_t(desc_t), .tagc_inp_t(tagc_inp_t), .r_chan_t(r_chan_t)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .tagctrl_desc_i(desc), .tagctrl_desc_valid_i(desc_valid), .tagctrl_desc_ready_o(desc_ready),
        .r_chan_mst_i(rin), .r_chan_valid_i(r_valid), .r_chan_ready_o(r_ready),
        .tagc_inp_r_i(tag), .tagc_inp_r_valid_i(tag_valid), .tagc_inp_r_ready_o(tag_ready),
        .r_chan_slv_o(rout), .r_chan_slv_valid_o(out_valid), .r_chan_slv_ready_i(out_ready),
        .len_err_o(len_err));

    // DUT B: 512-bit data, four capabilities per beat
    desc_t     b_desc;  logic b_desc_valid = 0, b_desc_ready;
    r512_t     b_rin;   logic b_r_valid = 0, b_r_ready;
    tagc_inp_t b_tag;   logic b_tag_valid = 0, b_tag_ready;
    r512_t     b_rout;  logic b_out_valid, b_out_ready = 0, b_len_err;

    axi_tagctrl_r_merge #(.Cfg(CfgB), .DescFifoDepth(4), .TagWordWidth(64),
        .tagctrl_desc_t(desc_t), .tagc_inp_t(tagc_inp_t), .r_chan_t(r512_t)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .tagctrl_desc_i(b_desc), .tagctrl_desc_valid_i(b_desc_valid), .tagctrl_desc_ready_o(b_desc_ready),
        .r_chan_mst_i(b_rin), .r_chan_valid_i(b_r_valid), .r_chan_ready_o(b_r_ready),
        .tagc_inp_r_i(b_tag), .tagc_inp_r_valid_i(b_tag_valid), .tagc_inp_r_ready_o(b_tag_ready),
        .r_chan_slv_o(b_rout), .r_chan_slv_valid_o(b_out_valid), .r_chan_slv_ready_i(b_out_ready),
        .len_err_o(b_len_err));

    desc_t     dq[$];
    r_chan_t   bq[$];
    tagc_inp_t tq[$];
    r_chan_t   got[16];
    logic      gerr[16];
    int        gcyc[16];
    int        ngot, unstable;

    function automatic desc_t mk_desc(input logic [47:0] a, input logic [7:0] len, input logic [3:0] id);
        desc_t d;
        d.a_x_addr = a; d.a_x_size = 3'd4; d.a_x_len = len; d.a_x_id = id; d.a_x_burst = 2'b01;
        return d;
    endfunction

    function automatic r_chan_t mk_beat(input logic [127:0] data, input logic [1:0] resp, input logic last);
        r_chan_t r;
        r.id = 4'hF; r.data = data; r.resp = resp; r.last = last; r.user = 4'hF;
        return r;
    endfunction

    task automatic push_descs();
        for (int k = 0; k < dq.size(); k++) begin
            int t;
            t = 0;
            @(negedge clk); desc = dq[k]; desc_valid = 1; #1;
            while (!desc_ready && t < 200) begin @(negedge clk); #1; t++; end
            if (t >= 200) begin errors++; $display("FAIL desc_timeout: ready=%0b required 1", desc_ready); end
        end
        @(negedge clk); desc_valid = 0;
    endtask

    task automatic push_beats();
        for (int k = 0; k < bq.size(); k++) begin
            int t;
            t = 0;
            @(negedge clk); rin = bq[k]; r_valid = 1; #1;
            while (!r_ready && t < 200) begin @(negedge clk); #1; t++; end
            if (t >= 200) begin errors++; $display("FAIL beat_timeout: ready=%0b required 1", r_ready); end
        end
        @(negedge clk); r_valid = 0;
    endtask

    task automatic push_tags();
        for (int k = 0; k < tq.size(); k++) begin
            int t;
            t = 0;
            @(negedge clk); tag = tq[k]; tag_valid = 1; #1;
            while (!tag_ready && t < 200) begin @(negedge clk); #1; t++; end
            if (t >= 200) begin errors++; $display("FAIL tag_timeout: ready=%0b required 1", tag_ready); end
        end
        @(negedge clk); tag_valid = 0;
    endtask

    // Records n output handshakes; also counts payload changes while stalled.
    task automatic collect(input int n, input bit rnd);
        r_chan_t hold;
        bit      pend;
        int      t;
        pend = 0; t = 0; ngot = 0; unstable = 0;
        while (ngot < n && t < 500) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pend && rout !== hold) unstable++;
            pend = 0;
            if (out_valid && out_ready) begin
                got[ngot] = rout; gerr[ngot] = len_err; gcyc[ngot] = cyc; ngot++;
            end else if (out_valid) begin
                hold = rout; pend = 1;
            end
            t++;
        end
        if (ngot < n) begin errors++; $display("FAIL collect_timeout: beats=%0d required %0d", ngot, n); end
        @(negedge clk); out_ready = 0;
    endtask

    task automatic run(input int n, input bit rnd);
        fork
            push_descs();
            push_beats();
            push_tags();
            collect(n, rnd);
        join
        dq.delete(); bq.delete(); tq.delete();
    endtask

    task automatic test_reset();
        #3;
        checks += 5;
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %0b required 0", out_valid); end
        if (len_err !== 1'b0)    begin errors++; $display("FAIL rst_len_err: got %0b required 0", len_err); end
        if (desc_ready !== 1'b1) begin errors++; $display("FAIL rst_desc_ready: got %0b required 1", desc_ready); end
        if (r_ready !== 1'b1)    begin errors++; $display("FAIL rst_r_ready: got %0b required 1", r_ready); end
        if (tag_ready !== 1'b1)  begin errors++; $display("FAIL rst_tag_ready: got %0b required 1", tag_ready); end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        dq.push_back(mk_desc(48'h40, 8'd0, 4'd3));
        bq.push_back(mk_beat(128'hABCD, 2'b00, 1'b1));
        tq.push_back('{data: 64'h10, err: 1'b0});
        run(1, 0);
        checks += 6;
        if (got[0].user !== 4'h1)      begin errors++; $display("FAIL single_user: got %h required 1", got[0].user); end
        if (got[0].id !== 4'd3)        begin errors++; $display("FAIL single_id: got %0d required 3", got[0].id); end
        if (got[0].last !== 1'b1)      begin errors++; $display("FAIL single_last: got %0b required 1", got[0].last); end
        if (got[0].data !== 128'hABCD) begin errors++; $display("FAIL single_data: got %h required abcd", got[0].data); end
        if (gerr[0] !== 1'b0)          begin errors++; $display("FAIL single_len_err: got %0b required 0", gerr[0]); end
        // collect() returns at the negedge right after the handshake
        #1;
        if (tag_ready !== 1'b1)        begin errors++; $display("FAIL single_tag_ready: got %0b required 1", tag_ready); end
    endtask

    task automatic test_region_crossing();
        logic [3:0] exp_user [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
        dq.push_back(mk_desc(48'd992, 8'd3, 4'd7));
        for (int i = 0; i < 4; i++) bq.push_back(mk_beat(128'(i + 1), 2'b00, i == 3));
        tq.push_back('{data: 64'h8000_0000_0000_0000, err: 1'b0});
        tq.push_back('{data: 64'h1, err: 1'b0});
        run(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (got[i].user !== exp_user[i]) begin errors++; $display("FAIL region_user[%0d]: got %h required %h", i, got[i].user, exp_user[i]); end
            if (got[i].data !== 128'(i + 1)) begin errors++; $display("FAIL region_data[%0d]: got %h required %h", i, got[i].data, i + 1); end
            if (gcyc[i] !== gcyc[0] + i)     begin errors++; $display("FAIL region_bubble[%0d]: cycle %0d required %0d", i, gcyc[i], gcyc[0] + i); end
        end
        checks++;
        if (tag_ready !== 1'b1) begin errors++; $display("FAIL region_tag_ready: got %0b required 1", tag_ready); end
    endtask

    task automatic test_multi_cap();
        r512_t bg[2];
        int n, t;
        n = 0; t = 0;
        @(negedge clk);
        b_desc = '{a_x_addr: 48'h0, a_x_size: 3'd6, a_x_len: 8'd1, a_x_id: 4'd2, a_x_burst: 2'b01};
        b_desc_valid = 1;
        b_tag = '{data: 64'hA5, err: 1'b0}; b_tag_valid = 1;
        b_rin = '{id: 4'h0, data: 512'h100, resp: 2'b00, last: 1'b0, user: 4'h0}; b_r_valid = 1;
        b_out_ready = 1;
        @(negedge clk);
        b_desc_valid = 0; b_tag_valid = 0;
        b_rin = '{id: 4'h0, data: 512'h200, resp: 2'b00, last: 1'b1, user: 4'h0};
        @(negedge clk); b_r_valid = 0;
        while (n < 2 && t < 50) begin
            #1;
            if (b_out_valid) begin bg[n] = b_rout; n++; end
            @(negedge clk); t++;
        end
        b_out_ready = 0;
        checks += 6;
        if (n !== 2) begin errors++; $display("FAIL multi_count: got %0d required 2", n); end
        if (bg[0].user !== 4'h5)     begin errors++; $display("FAIL multi_user0: got %h required 5", bg[0].user); end
        if (bg[1].user !== 4'hA)     begin errors++; $display("FAIL multi_user1: got %h required a", bg[1].user); end
        if (bg[0].data !== 512'h100) begin errors++; $display("FAIL multi_data0: got %h required 100", bg[0].data[15:0]); end
        if (bg[1].last !== 1'b1)     begin errors++; $display("FAIL multi_last1: got %0b required 1", bg[1].last); end
        if (bg[1].id !== 4'd2)       begin errors++; $display("FAIL multi_id1: got %0d required 2", bg[1].id); end
    endtask

    task automatic test_tag_error();
        logic [1:0] mem_resp [3] = '{2'b00, 2'b11, 2'b01};
        logic [1:0] exp_resp [3] = '{2'b10, 2'b11, 2'b10};
        dq.push_back(mk_desc(48'h0, 8'd2, 4'd9));
        for (int i = 0; i < 3; i++) bq.push_back(mk_beat(128'h50 + 128'(i), mem_resp[i], i == 2));
        tq.push_back('{data: 64'hFFFF_FFFF_FFFF_FFFF, err: 1'b1});
        run(3, 0);
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (got[i].resp !== exp_resp[i]) begin errors++; $display("FAIL err_resp[%0d]: got %b required %b", i, got[i].resp, exp_resp[i]); end
            if (got[i].user !== 4'h0)        begin errors++; $display("FAIL err_user[%0d]: got %h required 0", i, got[i].user); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_id   [6] = '{4'd1, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        logic [3:0] exp_user [6] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
        logic       exp_last [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int pass = 0; pass < 2; pass++) begin
            dq.push_back(mk_desc(48'h000, 8'd1, 4'd1));
            dq.push_back(mk_desc(48'h100, 8'd0, 4'd2));
            dq.push_back(mk_desc(48'h200, 8'd2, 4'd5));
            for (int i = 0; i < 6; i++) bq.push_back(mk_beat(128'h11 + 128'(i), 2'b00, exp_last[i]));
            tq.push_back('{data: 64'h3, err: 1'b0});
            tq.push_back('{data: 64'h1_0000, err: 1'b0});
            tq.push_back('{data: 64'h5_0000_0000, err: 1'b0});
            run(6, pass == 1);
            for (int i = 0; i < 6; i++) begin
                checks += 5;
                if (got[i].id !== exp_id[i])          begin errors++; $display("FAIL b2b%0d_id[%0d]: got %0d required %0d", pass, i, got[i].id, exp_id[i]); end
                if (got[i].user !== exp_user[i])      begin errors++; $display("FAIL b2b%0d_user[%0d]: got %h required %h", pass, i, got[i].user, exp_user[i]); end
                if (got[i].last !== exp_last[i])      begin errors++; $display("FAIL b2b%0d_last[%0d]: got %0b required %0b", pass, i, got[i].last, exp_last[i]); end
                if (got[i].data !== 128'h11 + 128'(i)) begin errors++; $display("FAIL b2b%0d_data[%0d]: got %h required %h", pass, i, got[i].data, 8'h11 + 8'(i)); end
                if (gerr[i] !== 1'b0)                 begin errors++; $display("FAIL b2b%0d_len_err[%0d]: got %0b required 0", pass, i, gerr[i]); end
                if (pass == 0) begin
                    checks++;
                    if (gcyc[i] !== gcyc[0] + i) begin errors++; $display("FAIL b2b_bubble[%0d]: cycle %0d required %0d", i, gcyc[i], gcyc[0] + i); end
                end
            end
            if (pass == 1) begin
                checks++;
                if (unstable !== 0) begin errors++; $display("FAIL b2b_stall_stable: changes=%0d required 0", unstable); end
            end
        end
    endtask

    task automatic test_len_mismatch();
        // Memory flags last early on beat 2 and again on beat 4: only beat 2 disagrees.
        logic mem_last [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic exp_err  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic exp_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_user [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
        dq.push_back(mk_desc(48'h300, 8'd3, 4'd4));
        for (int i = 0; i < 4; i++) bq.push_back(mk_beat(128'h70 + 128'(i), 2'b00, mem_last[i]));
        tq.push_back('{data: 64'h0006_0000_0000_0000, err: 1'b0});
        run(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (gerr[i] !== exp_err[i])        begin errors++; $display("FAIL len_err[%0d]: got %0b required %0b", i, gerr[i], exp_err[i]); end
            if (got[i].last !== exp_last[i])   begin errors++; $display("FAIL len_last[%0d]: got %0b required %0b", i, got[i].last, exp_last[i]); end
            if (got[i].user !== exp_user[i])   begin errors++; $display("FAIL len_user[%0d]: got %h required %h", i, got[i].user, exp_user[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        dq.push_back(mk_desc(48'h0, 8'd3, 4'd6));
        bq.push_back(mk_beat(128'h91, 2'b00, 1'b0));
        bq.push_back(mk_beat(128'h92, 2'b00, 1'b0));
        tq.push_back('{data: 64'h1, err: 1'b0});
        out_ready = 0;
        fork push_descs(); push_beats(); push_tags(); join
        dq.delete(); bq.delete(); tq.delete();
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %0b required 1", out_valid); end
        rst_n = 0; #1;
        checks += 4;
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid: got %0b required 0", out_valid); end
        if (desc_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_desc_ready: got %0b required 1", desc_ready); end
        if (r_ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_r_ready: got %0b required 1", r_ready); end
        if (tag_ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_tag_ready: got %0b required 1", tag_ready); end
        @(negedge clk); rst_n = 1; out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_rst_valid: got %0b required 0", out_valid); end
        out_ready = 0;
    endtask

    initial begin
        desc = '0; rin = '0; tag = '0; b_desc = '0; b_rin = '0; b_tag = '0;
        test_reset();
        test_single_beat();
        test_region_crossing();
        test_multi_cap();
        test_tag_error();
        test_back_to_back();
        test_len_mismatch();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
